// File: rtl/fadd_pipe.sv
// fadd_pipe: 3-stage pipelined floating-point add/sub (RNE, flush-to-zero, valid/ready).
// Define FADD_PIPE_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module fadd_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef FADD_PIPE_FLAGS_EN
    output logic [3:0]     flags,
`endif
    output logic [EW+MW:0] y
);
    localparam int W = 1 + EW + MW;
    localparam int MF = MW + 1;
    localparam int L = MF + 2;
    localparam int LZW = $clog2(MF + 5);
    localparam int XW = EW + LZW + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    logic en;
    assign en = out_ready | ~out_valid;
    assign in_ready = en;

    logic s1x, s2x, z1, z2, i1, i2, n1, n2, swap;
    logic [EW-1:0] e1x, e2x, ea, eb;
    logic [MW-1:0] m1x, m2x;
    logic [EW+MW-1:0] k1, k2, ka, kb;
    logic [MF-1:0] mfa, mfb;
    logic [XW-1:0] d, sh;
    logic [MF+L+1:0] ws;

    assign {s1x, e1x, m1x} = x1;
    assign {e2x, m2x} = x2[W-2:0];
    assign s2x = x2[W-1] ^ sub;
    assign z1 = e1x == '0;
    assign z2 = e2x == '0;
    assign i1 = &e1x & ~|m1x;
    assign i2 = &e2x & ~|m2x;
    assign n1 = &e1x & |m1x;
    assign n2 = &e2x & |m2x;
    // Flushed subnormals compare as zero magnitude; ties keep x1 as A
    assign k1 = z1 ? '0 : {e1x, m1x};
    assign k2 = z2 ? '0 : {e2x, m2x};
    assign swap = k2 > k1;
    assign ka = swap ? k2 : k1;
    assign kb = swap ? k1 : k2;
    assign ea = ka[EW+MW-1:MW];
    assign eb = kb[EW+MW-1:MW];
    assign mfa = {|ea, ka[MW-1:0]};
    assign mfb = {|eb, kb[MW-1:0]};
    assign d = XW'(ea) - XW'(eb);
    assign sh = d > XW'(L) ? XW'(L) : d;
    // Low L bits catch everything shifted past the round bit and fold into sticky
    assign ws = {mfb, {(L+2){1'b0}}} >> sh;

    logic v1, s1_sa, s1_sb, s1_nan, s1_inf;
    logic [EW-1:0] s1_e;
    logic [MF+2:0] s1_ma, s1_mb;
    logic v2, s2_sa, s2_sb, s2_nan, s2_inf;
    logic [EW-1:0] s2_e;
    logic [MF+3:0] s2_sum;

    always_ff @(posedge clk)
        if (en) begin
            s1_sa  <= swap ? s2x : s1x;
            s1_sb  <= swap ? s1x : s2x;
            s1_e   <= ea;
            s1_ma  <= {mfa, 3'b000};
            s1_mb  <= {ws[MF+L+1:L], |ws[L-1:0]};
            s1_nan <= n1 | n2 | (i1 & i2 & (s1x ^ s2x));
            s1_inf <= i1 | i2;
            s2_sa  <= s1_sa;
            s2_sb  <= s1_sb;
            s2_e   <= s1_e;
            s2_sum <= (s1_sa ^ s1_sb) ? {1'b0, s1_ma} - {1'b0, s1_mb} : {1'b0, s1_ma} + {1'b0, s1_mb};
            s2_nan <= s1_nan;
            s2_inf <= s1_inf;
        end

    logic [LZW-1:0] lzc;
    logic [MF+3:0] nrm;
    logic [MF:0] mr;
    logic signed [XW-1:0] er;
    logic g, r, st, up, zero, tiny, huge;
    logic [W-1:0] res;

    always_comb begin
        lzc = LZW'(MF + 4);
        for (int i = 0; i <= MF + 3; i++)
            if (s2_sum[i]) lzc = LZW'(MF + 3 - i);
    end

    // Leading one lands on the top bit, so the exponent moves by 1 - lzc
    assign nrm = s2_sum << lzc;
    assign {g, r} = nrm[3:2];
    assign st = |nrm[1:0];
    assign up = g & (r | st | nrm[4]);
    assign mr = {1'b0, nrm[MF+3:4]} + {{MF{1'b0}}, up};
    assign er = XW'(s2_e) + XW'(1) - XW'(lzc) + XW'(mr[MF]);
    assign zero = s2_sum == '0;
    assign tiny = er[XW-1] | (er == '0);
    assign huge = er >= EMAX;
    assign res = s2_nan ? QNAN
               : s2_inf ? {s2_sa, {EW{1'b1}}, {MW{1'b0}}}
               : zero   ? {s2_sa & s2_sb, {(W-1){1'b0}}}
               : tiny   ? {s2_sa, {(W-1){1'b0}}}
               : huge   ? {s2_sa, {EW{1'b1}}, {MW{1'b0}}}
               :          {s2_sa, er[EW-1:0], mr[MW-1:0]};

`ifdef FADD_PIPE_FLAGS_EN
    logic fin, ovf, unf;
    logic [3:0] fl;
    assign fin = ~s2_nan & ~s2_inf & ~zero;
    assign ovf = fin & ~tiny & huge;
    assign unf = fin & tiny;
    assign fl = {s2_nan, ovf, unf, ovf | unf | (fin & (g | r | st))};
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
`ifdef FADD_PIPE_FLAGS_EN
            flags     <= '0;
`endif
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            y         <= res;
`ifdef FADD_PIPE_FLAGS_EN
            flags     <= fl;
`endif
        end
endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: directed checks of fadd_pipe arithmetic, rounding, specials, backpressure, reset and half precision.
module tb_fadd_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] x1, x2, y;
    logic h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] hx1, hx2, hy;
`ifdef FADD_PIPE_FLAGS_EN
    logic [3:0] flags, h_flags;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fadd_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FADD_PIPE_FLAGS_EN
        .flags(flags),
`endif
        .y(y)
    );

    fadd_pipe #(.EW(5), .MW(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .x1(hx1), .x2(hx2), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
`ifdef FADD_PIPE_FLAGS_EN
        .flags(h_flags),
`endif
        .y(hy)
    );

    localparam int N = 19;
    logic [31:0] va [N] = '{32'h40400000, 32'h40400000, 32'h4048F5C3, 32'h3F800000, 32'h40200000,
                            32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h3FC00000, 32'h7F800001,
                            32'hFF800000, 32'h00400000, 32'h00800001, 32'h7F800000, 32'h4B800000,
                            32'h5E800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb [N] = '{32'hC0400000, 32'hC37F0000, 32'h40000000, 32'h3F8CCCCD, 32'h40000000,
                            32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h80000000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h00800000, 32'h7F800000, 32'h3F800000,
                            32'h3F800000, 32'h33000000, 32'h40400000, 32'h40400000};
    logic vs [N] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
    logic [31:0] ve [N] = '{32'h00000000, 32'hC37C0000, 32'h40A47AE2, 32'h40066666, 32'h3F000000,
                            32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h3FC00000, 32'h7FC00000,
                            32'hFF800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h4B800000,
                            32'h5E800000, 32'h3F800000, 32'h40800000, 32'hC0000000};
`ifdef FADD_PIPE_FLAGS_EN
    logic [3:0] vf [N] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h5, 4'h0, 4'h0, 4'h8,
                           4'h0, 4'h0, 4'h3, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    logic [3:0] hf [3] = '{4'h0, 4'h5, 4'h0};
`endif
    logic [15:0] ha [3] = '{16'h3C00, 16'h7BFF, 16'h3C00};
    logic [15:0] hb [3] = '{16'h3C00, 16'h7BFF, 16'h3C00};
    logic hs [3] = '{0, 0, 1};
    logic [15:0] he [3] = '{16'h4000, 16'h7C00, 16'h0000};

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b y=%h, want 0 00000000", out_valid, y);
        end
`ifdef FADD_PIPE_FLAGS_EN
        checks++;
        if (flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags: got %h want 0", flags);
        end
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_arith();
        out_ready = 1'b1;
        for (int c = 0; c < N + 3; c++) begin
            in_valid = c < N;
            if (c < N) begin
                x1 = va[c];
                x2 = vb[c];
                sub = vs[c];
            end
            @(posedge clk);
            #1;
            if (c >= 2 && c - 2 < N) begin
                checks++;
                if (out_valid !== 1'b1 || y !== ve[c-2]) begin
                    errors++;
                    $display("FAIL arith[%0d]: out_valid=%b y=%h, want 1 %h", c - 2, out_valid, y, ve[c-2]);
                end
`ifdef FADD_PIPE_FLAGS_EN
                checks++;
                if (flags !== vf[c-2]) begin
                    errors++;
                    $display("FAIL arith_flags[%0d]: got %h want %h", c - 2, flags, vf[c-2]);
                end
`endif
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL arith_latency cycle %0d: out_valid=%b want 0", c, out_valid);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] ba [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h40800000};
        logic [31:0] bb [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000};
        logic [31:0] be [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        logic [31:0] held = '0;
        logic started = 1'b0;
        int sent = 0;
        int rcv = 0;
        int stall = 0;
        int cyc = 0;
        sub = 1'b0;
        while (rcv < 5 && cyc < 60) begin
            if (out_valid === 1'b1 && !started) begin
                started = 1'b1;
                stall = 4;
                held = y;
            end
            out_ready = stall == 0;
            in_valid = sent < 5;
            if (sent < 5) begin
                x1 = ba[sent];
                x2 = bb[sent];
            end
            #1;
            if (stall > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== held) begin
                    errors++;
                    $display("FAIL bp_stall: in_ready=%b out_valid=%b y=%h, want 0 1 %h", in_ready, out_valid, y, held);
                end
                stall--;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (y !== be[rcv]) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got %h want %h", rcv, y, be[rcv]);
                end
                rcv++;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv != 5 || !started) begin
            errors++;
            $display("FAIL bp_count: received %0d want 5 (stalled=%b)", rcv, started);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra cycle %0d: out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        sub = 1'b0;
        x1 = 32'h3F800000;
        x2 = 32'h3F800000;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || y !== 32'h40000000) begin
            errors++;
            $display("FAIL rst_pre: out_valid=%b y=%h, want 1 40000000", out_valid, y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b y=%h, want 0 00000000", out_valid, y);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale cycle %0d: out_valid=%b want 0", c, out_valid);
            end
        end
        x1 = 32'h40000000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== (c == 3) || (c == 3 && y !== 32'h40800000)) begin
                errors++;
                $display("FAIL rst_relaunch edge %0d: out_valid=%b y=%h, want %0d 40800000", c, out_valid, y, c == 3);
            end
        end
    endtask

    task automatic test_half();
        h_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            h_in_valid = c < 3;
            if (c < 3) begin
                hx1 = ha[c];
                hx2 = hb[c];
                h_sub = hs[c];
            end
            @(posedge clk);
            #1;
            if (c >= 2) begin
                checks++;
                if (h_out_valid !== 1'b1 || hy !== he[c-2]) begin
                    errors++;
                    $display("FAIL half[%0d]: out_valid=%b y=%h, want 1 %h", c - 2, h_out_valid, hy, he[c-2]);
                end
`ifdef FADD_PIPE_FLAGS_EN
                checks++;
                if (h_flags !== hf[c-2]) begin
                    errors++;
                    $display("FAIL half_flags[%0d]: got %h want %h", c - 2, h_flags, hf[c-2]);
                end
`endif
            end
        end
        h_in_valid = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        x1 = '0;
        x2 = '0;
        sub = 1'b0;
        out_ready = 1'b1;
        h_in_valid = 1'b0;
        hx1 = '0;
        hx2 = '0;
        h_sub = 1'b0;
        h_out_ready = 1'b1;
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid();
        test_half();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Parametrised pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control.
- Next generation of the single-precision 3-stage adder:
  - generic exponent/mantissa widths
  - add/sub mode
  - round-to-nearest-even
  - special-value handling
  - backpressure
- Sits between the FPU operand issue logic and the writeback arbiter.

Parameters:
- EW, 8, exponent width in bits (bias = 2^(EW-1)-1).
- MW, 23, stored mantissa width in bits (hidden bit implicit).
- W = 1+EW+MW: derived localparam, not overridable.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: operands and op valid this cycle.
- in_ready, output, 1: block accepts input this cycle.
- x1, input, W: operand A.
- x2, input, W: operand B.
- sub, input, 1: 1 = compute x1-x2; 0 = compute x1+x2.
- out_valid, output, 1: y holds a result.
- out_ready, input, 1: consumer takes y this cycle.
- y, output, W: result.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - all stage valid bits, out_valid and y clear to 0.
  - in_ready reads 1 once rst deasserts.
  - An in-flight operation is discarded; nothing is emitted after reset.
- Pipeline: 3 register stages.
  - S1: unpack, apply sub (invert x2 sign), classify, swap so |A|>=|B|, align B by shift, keep guard/round/sticky.
  - S2: add/subtract with 3 extra low bits.
  - S3: leading-one normalise, RNE round, renormalise on mantissa carry, pack.
- Latency: 3 cycles from accepted input to out_valid with no stall.
- Throughput: 1 per cycle.
- Flow control:
  - Global enable en = out_ready | ~out_valid; in_ready = en.
  - All stages advance together when en=1 and hold otherwise.
  - Bubbles propagate as valid=0.
  - Transfer occurs on in_valid&in_ready and on out_valid&out_ready.
  - y and out_valid are stable while out_valid=1 and out_ready=0.
- Alignment:
  - Shift amount = eA-eB, saturated at MW+3.
  - All bits shifted past the round bit OR into sticky.
- Rounding: RNE. Round up if G & (R|S|LSB).
- Subnormals: flush-to-zero.
  - An input with exp=0 is treated as signed zero.
  - A result whose exponent falls to <=0 becomes signed zero.
- Overflow: rounded exponent >= 2^EW-1 yields signed infinity.
- Zeros:
  - Exact-zero result of opposite-signed operands gives +0.
  - -0 + -0 gives -0.
  - x + 0 returns x unchanged.
- Specials:
  - Any NaN input, or inf + (-inf) after sub inversion, yields canonical qNaN: sign 0, exp all ones, mantissa MSB 1, rest 0.
  - inf + finite yields that inf.
  - inf + same-sign inf yields inf.
- Equal-magnitude compare uses the full {exp,mantissa}. Ties pick x1 as A.

Optional Feature:
- Macro FADD_PIPE_FLAGS_EN.
- When defined, adds output port flags [3:0] = {invalid, overflow, underflow, inexact}.
  - flags is pipelined alongside y and valid with out_valid.
  - invalid: qNaN generated from inf-inf or NaN input.
  - overflow: rounded to inf from finite operands.
  - underflow: nonzero exact result flushed to zero.
  - inexact: any of G/R/S nonzero, or overflow, or underflow.
  - flags resets to 0.
- When undefined, the port and its logic are absent; y behaviour is identical.

Test Plan:
- Directed arithmetic, with out_ready=1 and one operation per cycle:
  - 0x40400000 + 0xC0400000 -> 0x00000000.
  - 0x40400000 + 0xC37F0000 -> 0xC37C0000.
  - Each result appears exactly 3 cycles after acceptance.
- RNE tie cases:
  - 0x4048F5C3 + 0x40000000 -> 0x40A47AE2 (odd LSB rounds up; truncation would give 0x40A47AE1).
  - 0x3F800000 + 0x3F8CCCCD -> 0x40066666 (even LSB stays).
- Sub mode and specials:
  - 0x40200000 sub 0x40000000 -> 0x3F000000.
  - 0x7F800000 sub 0x7F800000 -> 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; flags=0b0101 with FADD_PIPE_FLAGS_EN defined.
- Backpressure:
  - Stream 5 back-to-back inputs.
  - Hold out_ready=0 for 4 cycles starting when the first result is valid.
  - y holds steady and in_ready=0 during the stall.
  - All 5 results emerge in order, none lost or duplicated.
- Reset mid-operation:
  - Assert rst asynchronously (between clock edges) with 2 operations in flight.
  - out_valid and y drop to 0 immediately.
  - After release, no stale result appears; the next input has 3-cycle latency.
- Non-default widths:
  - With EW=5, MW=10, 0x3C00 + 0x3C00 -> 0x4000.
  - With EW=5, MW=10, 0x7BFF + 0x7BFF -> 0x7C00.
